voice_matcher: RTL



---
 rtl/biometrics_pkg.sv | 38 +++
 rtl/feature_template_ram.sv | 31 +++
 rtl/voice_matcher.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/biometrics_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// biometrics_pkg: shared mode/state encodings and the abs-diff helper
// Revision: 1.0
// ---------------------------------------------------------------------------
package biometrics_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_ENROLL = 2'b01,
    MODE_VERIFY = 2'b10
  } mode_e;

  typedef enum logic {
    ACCEPT = 1'b0,
    DECIDE = 1'b1
  } state_e;

  // Widest feature sample the helper supports; callers sign-extend to this.
  localparam int ABS_W = 64;

  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_ENROLL;
      2'b10:   return MODE_VERIFY;
      default: return MODE_IDLE;
    endcase
  endfunction

  function automatic logic [ABS_W:0] abs_diff(input logic signed [ABS_W-1:0] a,
                                              input logic signed [ABS_W-1:0] b);
    logic signed [ABS_W:0] d;
    d = {a[ABS_W-1], a} - {b[ABS_W-1], b};
    return d[ABS_W] ? -d : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/feature_template_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// feature_template_ram: enrolled template store, 1 write port, async read
// Revision: 1.0
// ---------------------------------------------------------------------------
module feature_template_ram #(
  parameter int FEATURE_WIDTH = 16,
  parameter int NUM_FEATURES  = 32,
  parameter int ADDR_W        = $clog2(NUM_FEATURES)
) (
  input  logic                     clk_in,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [FEATURE_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]        raddr_i,
  output logic [FEATURE_WIDTH-1:0] rdata_o
);

  // Contents deliberately survive reset so a template outlives a reset pulse.
  logic [FEATURE_WIDTH-1:0] mem_q [NUM_FEATURES];

  always_ff @(posedge clk_in) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/voice_matcher.sv
`default_nettype none
// ---------------------------------------------------------------------------
// voice_matcher: L1-distance speaker verification with N-frame confirmation
// Revision: 1.0
// ---------------------------------------------------------------------------
module voice_matcher
  import biometrics_pkg::*;
#(
  parameter int FEATURE_WIDTH = 16,
  parameter int NUM_FEATURES  = 32,
  parameter int MATCH_FRAMES  = 4,
  parameter int DIST_WIDTH    = FEATURE_WIDTH + 1 + $clog2(NUM_FEATURES)
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [1:0]                      mode_in,
  input  logic [DIST_WIDTH-1:0]           threshold_in,
  input  logic signed [FEATURE_WIDTH-1:0] feature_data_in,
  input  logic                            feature_valid_in,
  input  logic                            feature_last_in,
  output logic                            feature_ready_out,
  output logic                            enrolled_out,
  output logic [DIST_WIDTH-1:0]           distance_out,
  output logic                            distance_valid_out,
  output logic                            detected_out,
  output logic                            frame_error_out
);

  localparam int IDX_W = $clog2(NUM_FEATURES);
  localparam int CNT_W = $clog2(MATCH_FRAMES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_FEATURES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MATCH_FRAMES);

  state_e                   state_q, state_d;
  mode_e                    mode_q, mode_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DIST_WIDTH-1:0]    acc_q, acc_d;
  logic                     wellformed_q, wellformed_d;
  logic                     enrolled_q, enrolled_d;
  logic [DIST_WIDTH-1:0]    distance_q, distance_d;
  logic                     dvalid_q, dvalid_d;
  logic                     detected_q, detected_d;
  logic                     ferr_q, ferr_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic                     w_accept;
  logic                     w_we;
  mode_e                    w_beat_mode;
  logic [FEATURE_WIDTH-1:0] w_tmpl;
  logic [ABS_W:0]           w_abs_full;
  logic [FEATURE_WIDTH:0]   w_abs;
  logic                     w_abs_unused;

  feature_template_ram #(
    .FEATURE_WIDTH (FEATURE_WIDTH),
    .NUM_FEATURES  (NUM_FEATURES),
    .ADDR_W        (IDX_W)
  ) u_template (
    .clk_in  (clk_in),
    .we_i    (w_we),
    .waddr_i (idx_q),
    .wdata_i (feature_data_in),
    .raddr_i (idx_q),
    .rdata_o (w_tmpl)
  );

  // Ready is forced low while reset is held so every output reads 0 in reset.
  assign feature_ready_out = (state_q == ACCEPT) && rst_n_in;
  assign w_accept          = feature_valid_in && feature_ready_out;
  assign w_beat_mode       = (idx_q == '0) ? decode_mode(mode_in) : mode_q;

  assign w_abs_full   = abs_diff(ABS_W'(feature_data_in), ABS_W'($signed(w_tmpl)));
  assign w_abs        = w_abs_full[FEATURE_WIDTH:0];
  assign w_abs_unused = |w_abs_full[ABS_W:FEATURE_WIDTH+1];

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    wellformed_d = wellformed_q;
    enrolled_d   = enrolled_q;
    distance_d   = distance_q;
    dvalid_d     = 1'b0;
    detected_d   = detected_q;
    ferr_d       = 1'b0;
    count_d      = count_q;
    w_we         = 1'b0;

    case (state_q)
      ACCEPT: begin
        if (w_accept) begin
          if (idx_q == '0) begin
            mode_d = w_beat_mode;
          end
          if (w_beat_mode == MODE_ENROLL) begin
            w_we = 1'b1;
          end
          if (w_beat_mode == MODE_VERIFY) begin
            acc_d = acc_q + DIST_WIDTH'(w_abs);
          end
          // Either an early last or a full frame without last ends the frame.
          if (feature_last_in || (idx_q == LAST_IDX)) begin
            state_d      = DECIDE;
            wellformed_d = feature_last_in && (idx_q == LAST_IDX);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      DECIDE: begin
        state_d = ACCEPT;
        idx_d   = '0;
        acc_d   = '0;
        case (mode_q)
          MODE_ENROLL: begin
            enrolled_d = wellformed_q;
            ferr_d     = !wellformed_q;
            count_d    = '0;
            detected_d = 1'b0;
          end
          MODE_VERIFY: begin
            if (!wellformed_q) begin
              ferr_d     = 1'b1;
              count_d    = '0;
              detected_d = 1'b0;
            end else if (enrolled_q) begin
              distance_d = acc_q;
              dvalid_d   = 1'b1;
              if (acc_q <= threshold_in) begin
                count_d    = (count_q == CNT_FULL) ? CNT_FULL : count_q + CNT_W'(1);
                detected_d = ((count_q == CNT_FULL) ? CNT_FULL : count_q + CNT_W'(1)) == CNT_FULL;
              end else begin
                count_d    = '0;
                detected_d = 1'b0;
              end
            end
          end
          default: begin
          end
        endcase
      end

      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ACCEPT;
      mode_q       <= MODE_IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      wellformed_q <= 1'b0;
      enrolled_q   <= 1'b0;
      distance_q   <= '0;
      dvalid_q     <= 1'b0;
      detected_q   <= 1'b0;
      ferr_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      wellformed_q <= wellformed_d;
      enrolled_q   <= enrolled_d;
      distance_q   <= distance_d;
      dvalid_q     <= dvalid_d;
      detected_q   <= detected_d;
      ferr_q       <= ferr_d;
      count_q      <= count_d;
    end
  end

  assign enrolled_out       = enrolled_q;
  assign distance_out       = distance_q;
  assign distance_valid_out = dvalid_q;
  assign detected_out       = detected_q;
  assign frame_error_out    = ferr_q;

endmodule
`default_nettype wire
